// File: rtl/uart_rx_mf_if.sv
// Receive-FIFO read port of uart_rx_mf: first-word-fall-through head plus a one-clk pop strobe.
interface uart_rx_mf_if #(
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 8
);
    logic                         rd_en_i;
    logic [MAX_DATA_BITS-1:0]     rx_data_o;
    logic                         parity_error_o;
    logic                         frame_error_o;
    logic                         rx_valid_o;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count_o;

    modport slave  (input rd_en_i, output rx_data_o, parity_error_o, frame_error_o, rx_valid_o, fifo_count_o);
    modport master (output rd_en_i, input rx_data_o, parity_error_o, frame_error_o, rx_valid_o, fifo_count_o);
endinterface

// File: rtl/uart_rx_mf.sv
// Oversampling UART receiver with majority-vote bit sampling, parity/frame/break detection
// and a first-word-fall-through receive FIFO with sticky overrun and RTS flow control.
module uart_rx_mf #(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_tick,
    input  logic [3:0]           data_bits_i,
    input  logic                 parity_en_i,
    input  logic                 parity_type_i,
    input  logic                 stop_bit_num_i,
    input  logic                 rx,
    input  logic                 clr_overrun_i,
    output logic                 overrun_o,
    output logic                 break_o,
    output logic                 rts_n,
    uart_rx_mf_if.slave          rd_if
);
    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam int EW   = MAX_DATA_BITS + 2;
    localparam logic [CW-1:0] CNT_S0  = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] CNT_S1  = CW'(OVERSAMPLE/2);
    localparam logic [CW-1:0] CNT_S2  = CW'(OVERSAMPLE/2 + 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    MAXB    = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [3:0]               bit_idx_q, bit_idx_d;
    logic [MAX_DATA_BITS-1:0] data_q, data_d;
    logic                     par_q, par_d, v0_q, v0_d, v1_q, v1_d;
    logic                     stop_idx_q, stop_idx_d, stop0_q, stop0_d, ferr_q, ferr_d;
    logic                     rx_meta_q, rx_sync_q, rx_prev_q;
    logic                     maj_s, decide_s, end_s, ferr_now_s, perr_s, push_s, brk_s;
    logic [3:0]               nbits_s;
    logic [EW-1:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]            count_q;
    logic                     overrun_q, brk_q, rts_q;
    logic                     pop_s, full_s, wr_ok_s, ovr_set_s;
    logic [EW-1:0]            head_s;

    assign nbits_s    = (data_bits_i >= 4'd5 && data_bits_i <= MAXB) ? data_bits_i : MAXB;
    assign maj_s      = (v0_q & v1_q) | (v0_q & rx_sync_q) | (v1_q & rx_sync_q);
    assign decide_s   = rx_tick && (cnt_q == CNT_S2);
    assign end_s      = rx_tick && (cnt_q == CNT_END);
    assign ferr_now_s = ferr_q | ~maj_s;
    // Odd parity expects the XOR of data and parity bit to be 1, even expects 0.
    assign perr_s     = parity_en_i & (^data_q ^ par_q ^ ~parity_type_i);

    // Line synchronizer and edge-detect history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver FSM and datapath state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            bit_idx_q  <= 4'd0;
            data_q     <= {MAX_DATA_BITS{1'b0}};
            par_q      <= 1'b0;
            v0_q       <= 1'b1;
            v1_q       <= 1'b1;
            stop_idx_q <= 1'b0;
            stop0_q    <= 1'b1;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_q      <= par_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            stop_idx_q <= stop_idx_d;
            stop0_q    <= stop0_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state logic: the third vote sample is taken live at the decision tick.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_d      = par_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        stop_idx_d = stop_idx_q;
        stop0_d    = stop0_q;
        ferr_d     = ferr_q;
        push_s     = 1'b0;
        brk_s      = 1'b0;
        if (rx_tick) begin
            cnt_d = (cnt_q == CNT_END) ? {CW{1'b0}} : cnt_q + CW'(1);
            if (cnt_q == CNT_S0) begin
                v0_d = rx_sync_q;
            end else if (cnt_q == CNT_S1) begin
                v1_d = rx_sync_q;
            end else begin
                v0_d = v0_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            IDLE: begin
                cnt_d = {CW{1'b0}};
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (decide_s && maj_s) begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (end_s) begin
                    state_d   = DATA;
                    bit_idx_d = 4'd0;
                    data_d    = {MAX_DATA_BITS{1'b0}};
                    par_d     = 1'b0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (decide_s) begin
                    data_d[bit_idx_q] = maj_s;
                end else if (end_s) begin
                    if (bit_idx_q == nbits_s - 4'd1) begin
                        state_d    = parity_en_i ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                        ferr_d     = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (decide_s) begin
                    par_d = maj_s;
                end else if (end_s) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                    ferr_d     = 1'b0;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (decide_s) begin
                    ferr_d = ferr_now_s;
                    if (!stop_idx_q) begin
                        stop0_d = maj_s;
                    end else begin
                        stop0_d = stop0_q;
                    end
                    if (!stop_bit_num_i || stop_idx_q) begin
                        push_s  = 1'b1;
                        brk_s   = (data_q == {MAX_DATA_BITS{1'b0}}) && !(parity_en_i && par_q) &&
                                  !(stop_idx_q ? stop0_q : maj_s);
                        state_d = IDLE;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = STOP;
                    end
                end else if (end_s) begin
                    stop_idx_d = 1'b1;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    assign pop_s     = rd_if.rd_en_i && (count_q != {NW{1'b0}});
    assign full_s    = (count_q == NW'(FIFO_DEPTH));
    assign wr_ok_s   = push_s && (!full_s || pop_s);
    assign ovr_set_s = push_s && full_s && !pop_s;

    // FIFO storage; entries past the pointers are never observed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok_s) begin
            mem_q[wr_ptr_q] <= {data_q, perr_s, ferr_now_s};
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {NW{1'b0}};
            overrun_q <= 1'b0;
            brk_q     <= 1'b0;
            rts_q     <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_q + AW'(wr_ok_s);
            rd_ptr_q  <= rd_ptr_q + AW'(pop_s);
            case ({wr_ok_s, pop_s})
                2'b10:   count_q <= count_q + NW'(1);
                2'b01:   count_q <= count_q - NW'(1);
                default: count_q <= count_q;
            endcase
            overrun_q <= ovr_set_s | (overrun_q & ~clr_overrun_i);
            brk_q     <= brk_s;
            rts_q     <= (count_q >= NW'(FIFO_DEPTH - 1));
        end
    end

    assign head_s               = mem_q[rd_ptr_q];
    assign rd_if.rx_valid_o     = (count_q != {NW{1'b0}});
    assign rd_if.rx_data_o      = rd_if.rx_valid_o ? head_s[EW-1:2] : {MAX_DATA_BITS{1'b0}};
    assign rd_if.parity_error_o = rd_if.rx_valid_o & head_s[1];
    assign rd_if.frame_error_o  = rd_if.rx_valid_o & head_s[0];
    assign rd_if.fifo_count_o   = count_q;
    assign overrun_o            = overrun_q;
    assign break_o              = brk_q;
    assign rts_n                = rts_q;
endmodule

// File: tb/tb_uart_rx_mf.sv
// Scoreboard bench for uart_rx_mf: stimulus queues expected FIFO entries, a monitor drains and compares.
module tb_uart_rx_mf;
    localparam int BIT_CLKS = 64;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n, rx_tick, parity_en, parity_type, stop_bit_num, rx, clr_overrun;
    logic [3:0] data_bits;
    logic       overrun, brk, rts_n;
    logic       mon_rd = 1'b0, stim_rd = 1'b0;
    bit         allow = 1'b0;
    int         checks = 0, failures = 0, brk_pulses = 0, n_push = 0;
    ent_t       exp_q[$];

    uart_rx_mf_if #(.MAX_DATA_BITS(9), .FIFO_DEPTH(8)) rif ();
    assign rif.rd_en_i = mon_rd | stim_rd;

    uart_rx_mf #(.OVERSAMPLE(16), .MAX_DATA_BITS(9), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_tick(rx_tick), .data_bits_i(data_bits),
        .parity_en_i(parity_en), .parity_type_i(parity_type), .stop_bit_num_i(stop_bit_num),
        .rx(rx), .clr_overrun_i(clr_overrun), .overrun_o(overrun), .break_o(brk),
        .rts_n(rts_n), .rd_if(rif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // rx_tick every 4 clocks, so one bit lasts 64 clocks.
    initial begin
        int div = 0;
        rx_tick = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            rx_tick = (div == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (brk === 1'b1) brk_pulses++;
        end
    end

    // Monitor: compares and pops the head whenever the DUT presents data and draining is allowed.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            mon_rd = 1'b0;
            if (allow && rif.rx_valid_o === 1'b1) begin
                check("sb_expected_word", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rif.rx_data_o), 32'(e.d));
                    check("parity_error", 32'(rif.parity_error_o), 32'(e.pe));
                    check("frame_error", 32'(rif.frame_error_o), 32'(e.fe));
                end
                mon_rd = 1'b1;
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic drive_bit_glitch(input logic b);
        rx = b;
        repeat (32) @(negedge clk);
        rx = ~b;
        repeat (4) @(negedge clk);
        rx = b;
        repeat (BIT_CLKS - 36) @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input bit pen, input logic pbit, input int nstop);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        for (int i = 0; i < nstop; i++) drive_bit(1'b1);
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic pen, input logic ptype, input logic nstop);
        data_bits = nb; parity_en = pen; parity_type = ptype; stop_bit_num = nstop;
    endtask

    task automatic expect_word(input logic [8:0] d, input logic pe, input logic fe);
        ent_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int k = 0;
        allow = 1'b1;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        allow = 1'b0;
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_empty"}, 32'(rif.rx_valid_o), 32'd0);
    endtask

    initial begin
        int   n;
        ent_t e;
        rst_n = 1'b0; rx = 1'b1; clr_overrun = 1'b0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(rif.rx_valid_o), 32'd0);
        check("rst_count", 32'(rif.fifo_count_o), 32'd0);
        check("rst_data", 32'(rif.rx_data_o), 32'd0);
        check("rst_flags", 32'({rif.parity_error_o, rif.frame_error_o}), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_break", 32'(brk), 32'd0);
        check("rst_rts_n", 32'(rts_n), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rts_n_after_release", 32'(rts_n), 32'd0);
        repeat (8) @(negedge clk);

        // 8N1 0xA5
        expect_word(9'h0A5, 1'b0, 1'b0);
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1);
        check("a5_count", 32'(rif.fifo_count_o), 32'd1);
        drain("a5");

        // 9 data bits, 2 stop: 0x1FF has nine ones, so even parity needs a 1 and odd parity a 0.
        set_cfg(4'd9, 1'b1, 1'b1, 1'b1);
        expect_word(9'h1FF, 1'b0, 1'b0);
        send_frame(9'h1FF, 9, 1'b1, 1'b1, 2);
        expect_word(9'h1FF, 1'b1, 1'b0);
        send_frame(9'h1FF, 9, 1'b1, 1'b0, 2);
        set_cfg(4'd9, 1'b1, 1'b0, 1'b1);
        expect_word(9'h1FF, 1'b0, 1'b0);
        send_frame(9'h1FF, 9, 1'b1, 1'b0, 2);
        check("par_count", 32'(rif.fifo_count_o), 32'd3);
        // 5 data bits, odd parity: 0x13 has three ones.
        set_cfg(4'd5, 1'b1, 1'b0, 1'b0);
        expect_word(9'h013, 1'b0, 1'b0);
        send_frame(9'h013, 5, 1'b1, 1'b0, 1);
        // Illegal data_bits falls back to 9 bits; a zero stop bit is a frame error.
        set_cfg(4'd2, 1'b0, 1'b0, 1'b0);
        expect_word(9'h155, 1'b0, 1'b0);
        send_frame(9'h155, 9, 1'b0, 1'b0, 1);
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        expect_word(9'h081, 1'b0, 1'b1);
        send_frame(9'h081, 8, 1'b0, 1'b0, 0);
        drive_bit(1'b0);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        drain("cfg");

        // Short start pulse of 5 ticks is rejected.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS * 12) @(negedge clk);
        check("glitch_start_count", 32'(rif.fifo_count_o), 32'd0);

        // One-tick glitches inside data bits 2 and 6 are outvoted.
        expect_word(9'h03C, 1'b0, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 6) drive_bit_glitch(i[2] ^ i[1] ? 1'b1 : 1'b0);
            else drive_bit((i >= 2 && i <= 5) ? 1'b1 : 1'b0);
        end
        drive_bit(1'b1);
        drain("glitch_data");

        // Break: line low for 12 bit times.
        n = brk_pulses;
        expect_word(9'h000, 1'b0, 1'b1);
        repeat (12) drive_bit(1'b0);
        drive_bit(1'b1);
        check("break_pulses", 32'(brk_pulses - n), 32'd1);
        check("break_count", 32'(rif.fifo_count_o), 32'd1);
        drain("break");

        // Back-to-back frames without reads: rts_n, fill, overrun.
        for (int k = 1; k <= 8; k++) begin
            expect_word(9'(k * 17), 1'b0, 1'b0);
            send_frame(9'(k * 17), 8, 1'b0, 1'b0, 1);
            if (k == 6) check("rts_n_at_6", 32'(rts_n), 32'd0);
            if (k == 7) check("rts_n_at_7", 32'(rts_n), 32'd1);
        end
        check("full_overrun_clear", 32'(overrun), 32'd0);
        n = 0;
        fork
            send_frame(9'h099, 8, 1'b0, 1'b0, 1);
            begin
                while (overrun !== 1'b1 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_count", 32'(rif.fifo_count_o), 32'd8);
        @(negedge clk); clr_overrun = 1'b1;
        @(negedge clk); clr_overrun = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);
        repeat (6) @(negedge clk);
        // Pop lands on the same clock as the 10th push (same tick phase as frame 9).
        fork
            send_frame(9'h0AA, 8, 1'b0, 1'b0, 1);
            begin
                if (n >= 2 && n < 2000) begin
                    repeat (n - 1) @(negedge clk);
                    e = exp_q.pop_front();
                    check("pop_head", 32'(rif.rx_data_o), 32'(e.d));
                    stim_rd = 1'b1;
                    @(negedge clk);
                    stim_rd = 1'b0;
                    check("push_pop_full_count", 32'(rif.fifo_count_o), 32'd8);
                    check("push_pop_no_overrun", 32'(overrun), 32'd0);
                end else begin
                    check("overrun_latency_found", 32'(n), 32'd0);
                end
            end
        join
        expect_word(9'h0AA, 1'b0, 1'b0);
        check("full_rts_n", 32'(rts_n), 32'd1);
        drain("overrun");

        // Reset pulsed mid-DATA: 0xF0 keeps the line high after the reset point.
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(i == 4 ? 1'b1 : 1'b0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT_CLKS * 5) @(negedge clk);
        check("midreset_count", 32'(rif.fifo_count_o), 32'd0);
        check("midreset_valid", 32'(rif.rx_valid_o), 32'd0);

        check("total_break_pulses", 32'(brk_pulses), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
